fifo_wptr_wfull: RTL and testbench

FIFO_WPTR_WFULL -- requirements
Module: fifo_wptr_wfull

---
 rtl/fifo_wptr_wfull.sv | 94 +++++++++
 tb/tb_fifo_wptr_wfull.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_wfull.sv
// Write-side pointer and flag logic of an async FIFO: Gray write pointer, synchronized
// read pointer, and pessimistic full / almost-full / level / sticky overflow flags.
module fifo_wptr_wfull #(
    parameter int Address_width      = 3,
    parameter int Almost_full_margin = 1
) (
    input  logic                     Wclk,
    input  logic                     Wrst,
    input  logic                     Winc,
    input  logic [Address_width:0]   Rptr,
    output logic [Address_width-1:0] Wadder,
    output logic [Address_width:0]   Wptr,
    output logic                     Wfull,
    output logic                     Walmost_full,
    output logic                     Woverflow,
    output logic [Address_width:0]   Wlevel,
    output logic [Address_width:0]   W2q_rptr
);

    localparam int AW    = Address_width;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] AF_THRESH = (AW+1)'(DEPTH - Almost_full_margin);

    logic [AW:0] r_meta;
    logic [AW:0] r_sync;
    logic [AW:0] r_bin;
    logic [AW:0] r_wptr;
    logic        r_full;
    logic        r_afull;
    logic        r_ovf;
    logic [AW:0] r_level;

    logic        w_wr;
    logic [AW:0] w_bin_next;
    logic [AW:0] w_gray_next;
    logic [AW:0] w_rbin;
    logic [AW:0] w_level;
    logic        w_full;
    logic        w_afull;

    // Plain two-flop synchronizer; nothing may sit between the stages.
    always_ff @(posedge Wclk or posedge Wrst) begin
        if (Wrst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= Rptr;
            r_sync <= r_meta;
        end
    end

    assign w_wr        = Winc & ~r_full;
    assign w_bin_next  = r_bin + {{AW{1'b0}}, w_wr};
    assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i <= AW; i++)
            w_rbin[i] = ^(r_sync >> i);
    end

    assign w_level = w_bin_next - w_rbin;
    assign w_full  = (w_gray_next == {~r_sync[AW:AW-1], r_sync[AW-2:0]});
    assign w_afull = (w_level >= AF_THRESH) | w_full;

    always_ff @(posedge Wclk or posedge Wrst) begin
        if (Wrst) begin
            r_bin   <= '0;
            r_wptr  <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_ovf   <= 1'b0;
            r_level <= '0;
        end else begin
            r_bin   <= w_bin_next;
            r_wptr  <= w_gray_next;
            r_full  <= w_full;
            r_afull <= w_afull;
            r_level <= w_level;
            if (Winc && r_full)
                r_ovf <= 1'b1;
        end
    end

    assign Wadder       = r_bin[AW-1:0];
    assign Wptr         = r_wptr;
    assign Wfull        = r_full;
    assign Walmost_full = r_afull;
    assign Woverflow    = r_ovf;
    assign Wlevel       = r_level;
    assign W2q_rptr     = r_sync;

endmodule

// File: tb/tb_fifo_wptr_wfull.sv
// Bench for fifo_wptr_wfull (depth 8, margin 1): vector table through a scoreboard queue,
// plus hand sequences for async reset, simultaneous read/write and pointer wrap.
module tb_fifo_wptr_wfull;

    typedef struct {
        logic       winc;
        logic [3:0] rptr;
        logic [3:0] wptr;
        logic [2:0] wadder;
        logic       full;
        logic       afull;
        logic       ovf;
        logic [3:0] level;
        logic [3:0] w2q;
        bit         partial;
    } vec_t;

    logic       Wclk, Wrst, Winc;
    logic [3:0] Rptr;
    logic [2:0] Wadder;
    logic [3:0] Wptr, Wlevel, W2q_rptr;
    logic       Wfull, Walmost_full, Woverflow;

    int   n_chk  = 0;
    int   n_pass = 0;
    vec_t sb[$];
    vec_t tbl[$];

    fifo_wptr_wfull #(.Address_width(3), .Almost_full_margin(1)) dut (
        .Wclk(Wclk), .Wrst(Wrst), .Winc(Winc), .Rptr(Rptr),
        .Wadder(Wadder), .Wptr(Wptr), .Wfull(Wfull), .Walmost_full(Walmost_full),
        .Woverflow(Woverflow), .Wlevel(Wlevel), .W2q_rptr(W2q_rptr)
    );

    initial Wclk = 1'b0;
    always #5 Wclk = ~Wclk;

    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic vec_t mk(input logic winc, input logic [3:0] rptr, input logic [3:0] wptr,
                                input logic [2:0] wadder, input logic full, input logic afull,
                                input logic ovf, input logic [3:0] level, input logic [3:0] w2q,
                                input bit partial = 1'b0);
        vec_t v;
        v.winc = winc; v.rptr = rptr; v.wptr = wptr; v.wadder = wadder; v.full = full;
        v.afull = afull; v.ovf = ovf; v.level = level; v.w2q = w2q; v.partial = partial;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_wptr"},  Wptr, 0);
        chk({nm, "_wadder"}, Wadder, 0);
        chk({nm, "_wfull"}, Wfull, 0);
        chk({nm, "_afull"}, Walmost_full, 0);
        chk({nm, "_ovf"},   Woverflow, 0);
        chk({nm, "_level"}, Wlevel, 0);
        chk({nm, "_w2q"},   W2q_rptr, 0);
    endtask

    // Drive one cycle, queue its expectation, then compare just after the edge.
    task automatic apply(input vec_t v);
        vec_t e;
        Winc = v.winc;
        Rptr = v.rptr;
        sb.push_back(v);
        @(posedge Wclk);
        #1;
        e = sb.pop_front();
        chk("wptr", Wptr, e.wptr);
        chk("wadder", Wadder, e.wadder);
        chk("wfull", Wfull, e.full);
        if (!e.partial) begin
            chk("afull", Walmost_full, e.afull);
            chk("ovf", Woverflow, e.ovf);
            chk("level", Wlevel, e.level);
            chk("w2q", W2q_rptr, e.w2q);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Wrst = 1'b1; Winc = 1'b0; Rptr = 4'b0000;
        #1;
        chk_all_zero("reset");
        @(posedge Wclk); #1;
        Wrst = 1'b0;

        // fill, overflow, drain
        tbl.push_back(mk(1, 4'b0000, 4'b0001, 3'd1, 0, 0, 0, 4'd1, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 4'b0011, 3'd2, 0, 0, 0, 4'd2, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 4'b0010, 3'd3, 0, 0, 0, 4'd3, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 4'b0110, 3'd4, 0, 0, 0, 4'd4, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 4'b0111, 3'd5, 0, 0, 0, 4'd5, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 4'b0101, 3'd6, 0, 0, 0, 4'd6, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 4'b0100, 3'd7, 0, 1, 0, 4'd7, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 4'b1100, 3'd0, 1, 1, 0, 4'd8, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 4'b1100, 3'd0, 1, 1, 1, 4'd8, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'b1100, 3'd0, 1, 1, 1, 4'd8, 4'b0000));
        tbl.push_back(mk(0, 4'b0001, 4'b1100, 3'd0, 1, 1, 1, 4'd8, 4'b0000));
        tbl.push_back(mk(0, 4'b0001, 4'b1100, 3'd0, 1, 1, 1, 4'd8, 4'b0001));
        tbl.push_back(mk(0, 4'b0001, 4'b1100, 3'd0, 0, 1, 1, 4'd7, 4'b0001));
        foreach (tbl[i]) apply(tbl[i]);

        // async reset mid-cycle, with a write request pending
        Rptr = 4'b0000;
        #2;
        Wrst = 1'b1; Winc = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(posedge Wclk); #1;
        chk_all_zero("rst_hold");
        Wrst = 1'b0;
        apply(mk(1, 4'b0000, 4'b0001, 3'd1, 0, 0, 0, 4'd1, 4'b0000));
        for (int k = 2; k <= 5; k++)
            apply(mk(1, 4'b0000, gray(k), 3'(k), 0, 0, 0, 4'(k), 4'b0000));

        // read advance reaches the flags on the same edge as a write: level holds at 5
        apply(mk(0, 4'b0001, 4'b0111, 3'd5, 0, 0, 0, 4'd5, 4'b0000));
        apply(mk(0, 4'b0001, 4'b0111, 3'd5, 0, 0, 0, 4'd5, 4'b0001));
        apply(mk(1, 4'b0001, 4'b0101, 3'd6, 0, 0, 0, 4'd5, 4'b0001));

        // wrap: reader trails the writer by three, so full must never appear
        Wrst = 1'b1; Winc = 1'b0; Rptr = 4'b0000;
        #1;
        @(posedge Wclk); #1;
        Wrst = 1'b0;
        for (int k = 1; k <= 16; k++)
            apply(mk(1, gray((k > 3) ? k - 3 : 0), gray(k % 16), 3'(k % 8), 0, 0, 0, 4'd0, 4'd0, 1'b1));
        chk("wrap_wptr", Wptr, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
